// File: rtl/std_lane_bridge.sv
// std_lane_bridge: fans an out-of-band transaction command onto a set of
// stack-bus lanes, buffering each lane's SOD..EOD stream in a small FIFO
// toward the PE array and pulsing txn_done once every masked lane has
// delivered its EOD.
//
// Parameters: NUM_LANES, DATA_W, FIFO_DEPTH (power of 2, >= 2)
// Ports:
//   clk, reset_poweron (async, active-low)
//   oob_cmd_valid/oob_cmd_lane_mask/oob_cmd_ready : transaction start handshake
//   in_valid/in_data/in_cntl/in_ready             : per-lane upstream, cntl={EOD,SOD}
//   out_valid/out_data/out_cntl/out_ready         : per-lane downstream
//   txn_done  : one-cycle completion pulse
//   proto_err : sticky protocol error
// Optional feature: define STD_LANE_BRIDGE_PROTO_CHK_EN to build the protocol
// checker; otherwise proto_err is tied low.

module std_lane_bridge #(
  parameter int unsigned NUM_LANES  = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset_poweron,
  input  logic                          oob_cmd_valid,
  input  logic [NUM_LANES-1:0]          oob_cmd_lane_mask,
  output logic                          oob_cmd_ready,
  input  logic [NUM_LANES-1:0]          in_valid,
  input  logic [NUM_LANES*DATA_W-1:0]   in_data,
  input  logic [NUM_LANES*2-1:0]        in_cntl,
  output logic [NUM_LANES-1:0]          in_ready,
  output logic [NUM_LANES-1:0]          out_valid,
  output logic [NUM_LANES*DATA_W-1:0]   out_data,
  output logic [NUM_LANES*2-1:0]        out_cntl,
  input  logic [NUM_LANES-1:0]          out_ready,
  output logic                          txn_done,
  output logic                          proto_err
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned ENT_W = DATA_W + 2;

  typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN, DONE} state_t;

  state_t state, next_state;

  logic [NUM_LANES-1:0] mask_q;
  logic [NUM_LANES-1:0] eod_in;
  logic [NUM_LANES-1:0] eod_out;
  logic [NUM_LANES-1:0] eod_in_nxt;
  logic [NUM_LANES-1:0] in_eod;
  logic [NUM_LANES-1:0] out_eod;
  logic [NUM_LANES-1:0] push;
  logic [NUM_LANES-1:0] pop;
  logic [NUM_LANES-1:0] lane_empty;
  logic                 cmd_ready_q;
  logic                 txn_done_q;
  logic                 cmd_accept;

  logic [PTR_W-1:0] wr_ptr [NUM_LANES];
  logic [PTR_W-1:0] rd_ptr [NUM_LANES];
  logic [CNT_W-1:0] count  [NUM_LANES];
  logic [ENT_W-1:0] mem    [NUM_LANES][FIFO_DEPTH];

  assign oob_cmd_ready = cmd_ready_q;
  assign txn_done      = txn_done_q;
  assign cmd_accept    = oob_cmd_valid & cmd_ready_q;

  // Per-lane handshakes and head-of-FIFO presentation.
  // A full lane refuses a push even while popping: no same-cycle pass-through.
  always_comb begin
    in_ready   = '0;
    out_valid  = '0;
    out_data   = '0;
    out_cntl   = '0;
    push       = '0;
    pop        = '0;
    lane_empty = '0;
    in_eod     = '0;
    out_eod    = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      lane_empty[i] = (count[i] == '0);
      in_ready[i]   = (state == ACTIVE) && mask_q[i] && !eod_in[i] &&
                      (count[i] < CNT_W'(FIFO_DEPTH));
      out_valid[i]  = !lane_empty[i];
      out_data[i*DATA_W +: DATA_W] = mem[i][rd_ptr[i]][DATA_W-1:0];
      out_cntl[i*2 +: 2]           = mem[i][rd_ptr[i]][ENT_W-1 -: 2];
      in_eod[i]     = in_cntl[i*2+1];
      out_eod[i]    = mem[i][rd_ptr[i]][ENT_W-1];
      push[i]       = in_valid[i] & in_ready[i];
      pop[i]        = out_valid[i] & out_ready[i];
    end
    eod_in_nxt = eod_in | (push & in_eod);
  end

  // Transaction sequencing.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (cmd_accept) begin
          next_state = (oob_cmd_lane_mask != '0) ? ACTIVE : DONE;
        end
      end
      ACTIVE: begin
        if (&(eod_in_nxt | ~mask_q)) next_state = DRAIN;
      end
      DRAIN: begin
        if ((&(eod_out | ~mask_q)) && (&lane_empty)) next_state = DONE;
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // State, transaction flags and registered status outputs.
  always_ff @(posedge clk or negedge reset_poweron) begin
    if (!reset_poweron) begin
      state       <= IDLE;
      mask_q      <= '0;
      eod_in      <= '0;
      eod_out     <= '0;
      cmd_ready_q <= 1'b0;
      txn_done_q  <= 1'b0;
    end else begin
      state       <= next_state;
      cmd_ready_q <= (next_state == IDLE);
      txn_done_q  <= (next_state == DONE);
      if (state == DONE) begin
        mask_q  <= '0;
        eod_in  <= '0;
        eod_out <= '0;
      end else begin
        if (state == IDLE && cmd_accept) mask_q <= oob_cmd_lane_mask;
        eod_in  <= eod_in_nxt;
        eod_out <= eod_out | (pop & out_eod);
      end
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally since depth is 2^n.
  always_ff @(posedge clk or negedge reset_poweron) begin
    if (!reset_poweron) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
        case ({push[i], pop[i]})
          2'b10:   count[i] <= count[i] + CNT_W'(1);
          2'b01:   count[i] <= count[i] - CNT_W'(1);
          default: count[i] <= count[i];
        endcase
      end
    end
  end

  // FIFO storage: {cntl, data} per entry.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_LANES; i++) begin
      if (push[i]) mem[i][wr_ptr[i]] <= {in_cntl[i*2 +: 2], in_data[i*DATA_W +: DATA_W]};
    end
  end

`ifdef STD_LANE_BRIDGE_PROTO_CHK_EN
  logic [NUM_LANES-1:0] started;
  logic                 err_c;

  // Flags traffic on unmasked lanes and SOD framing violations.
  always_comb begin
    err_c = 1'b0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if ((state == ACTIVE) && in_valid[i] && !mask_q[i]) err_c = 1'b1;
      if (push[i] && started[i] && in_cntl[i*2])          err_c = 1'b1;
      if (push[i] && !started[i] && !in_cntl[i*2])        err_c = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_poweron) begin
    if (!reset_poweron) begin
      started   <= '0;
      proto_err <= 1'b0;
    end else begin
      proto_err <= proto_err | err_c;
      started   <= (state == DONE) ? '0 : (started | push);
    end
  end
`else
  assign proto_err = 1'b0;
`endif

endmodule
